// File: rtl/ara_pkg.sv
// Shared Ara types for the XIF result path.
package ara_pkg;

    localparam int unsigned XIF_ID_W = ariane_pkg::TRANS_ID_BITS;
    localparam int unsigned XIF_XLEN = 64;

    typedef struct packed {
        logic [XIF_ID_W-1:0] id;
        logic [XIF_XLEN-1:0] data;
        logic [4:0]          rd;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } xif_result_entry_t;

endpackage

// File: rtl/ariane_pkg.sv
// Minimal host-core constants needed by the XIF result queue.
package ariane_pkg;

    localparam int unsigned TRANS_ID_BITS = 3;

endpackage

// File: rtl/ara_xif_result_queue.sv
// Registered FIFO between the Ara dispatcher and the XIF result channel.
// Optional feature: define ARA_XIF_RESULT_EXC_EN to carry exception info.
module ara_xif_result_queue
    import ara_pkg::*;
#(
    parameter int unsigned ID_WIDTH = ariane_pkg::TRANS_ID_BITS,
    parameter int unsigned XLEN     = 64,
    parameter int unsigned DEPTH    = 4,
    localparam int unsigned CW      = $clog2(DEPTH + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                res_valid_i,
    output logic                res_ready_o,
    input  logic [ID_WIDTH-1:0] res_id_i,
    input  logic [XLEN-1:0]     res_data_i,
    input  logic [4:0]          res_rd_i,
    input  logic                res_we_i,
    input  logic [5:0]          res_exccode_i,
    input  logic                res_exc_i,
    input  logic                flush_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [XLEN-1:0]     result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                result_exc_o,
    output logic [5:0]          result_exccode_o,
    output logic [CW-1:0]       count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    xif_result_entry_t mem [DEPTH];
    xif_result_entry_t wr_entry;
    xif_result_entry_t head;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    assign res_ready_o    = (count < CW'(DEPTH)) && !flush_i;
    assign result_valid_o = (count != '0);
    assign push           = res_valid_i && res_ready_o;
    assign pop            = result_valid_o && result_ready_i;
    assign count_o        = count;

    // Data is zeroed at write time so the output stays a plain register read.
    always_comb begin
        wr_entry      = '0;
        wr_entry.id   = XIF_ID_W'(res_id_i);
        wr_entry.rd   = res_rd_i;
        wr_entry.we   = res_we_i;
        wr_entry.data = res_we_i ? XIF_XLEN'(res_data_i) : '0;
`ifdef ARA_XIF_RESULT_EXC_EN
        wr_entry.exc     = res_exc_i;
        wr_entry.exccode = res_exccode_i;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head          = mem[rd_ptr];
    assign result_id_o   = head.id[ID_WIDTH-1:0];
    assign result_data_o = head.data[XLEN-1:0];
    assign result_rd_o   = head.rd;
    assign result_we_o   = head.we;

`ifdef ARA_XIF_RESULT_EXC_EN
    assign result_exc_o     = head.exc;
    assign result_exccode_o = head.exccode;
`else
    logic unused_exc;
    assign unused_exc       = ^{res_exc_i, res_exccode_i, head.exc, head.exccode};
    assign result_exc_o     = 1'b0;
    assign result_exccode_o = '0;
`endif

endmodule

// File: tb/tb_ara_xif_result_queue.sv
// Scoreboard bench for ara_xif_result_queue: directed cases then random traffic.
module tb_ara_xif_result_queue;

    localparam int IDW   = 3;
    localparam int XL    = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [IDW-1:0] id;
        logic [XL-1:0]  data;
        logic [4:0]     rd;
        logic           we;
        logic           exc;
        logic [5:0]     code;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           res_valid_i = 1'b0;
    logic           res_ready_o;
    logic [IDW-1:0] res_id_i = '0;
    logic [XL-1:0]  res_data_i = '0;
    logic [4:0]     res_rd_i = '0;
    logic           res_we_i = 1'b0;
    logic [5:0]     res_exccode_i = '0;
    logic           res_exc_i = 1'b0;
    logic           flush_i = 1'b0;
    logic           result_valid_o;
    logic           result_ready_i = 1'b0;
    logic [IDW-1:0] result_id_o;
    logic [XL-1:0]  result_data_o;
    logic [4:0]     result_rd_o;
    logic           result_we_o;
    logic           result_exc_o;
    logic [5:0]     result_exccode_o;
    logic [CW-1:0]  count_o;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    exp_t exp_q[$];

    ara_xif_result_queue #(
        .ID_WIDTH(IDW),
        .XLEN    (XL),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .res_valid_i     (res_valid_i),
        .res_ready_o     (res_ready_o),
        .res_id_i        (res_id_i),
        .res_data_i      (res_data_i),
        .res_rd_i        (res_rd_i),
        .res_we_i        (res_we_i),
        .res_exccode_i   (res_exccode_i),
        .res_exc_i       (res_exc_i),
        .flush_i         (flush_i),
        .result_valid_o  (result_valid_o),
        .result_ready_i  (result_ready_i),
        .result_id_o     (result_id_o),
        .result_data_o   (result_data_o),
        .result_rd_o     (result_rd_o),
        .result_we_o     (result_we_o),
        .result_exc_o    (result_exc_o),
        .result_exccode_o(result_exccode_o),
        .count_o         (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT against the reference queue, then advance the
    // reference with the inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (chk_en) begin
            bit acc;
            bit pp;
            exp_t e;
            chk("count", 64'(count_o), 64'(exp_q.size()));
            chk("valid", 64'(result_valid_o), 64'(exp_q.size() != 0));
            chk("ready", 64'(res_ready_o), 64'(exp_q.size() < DEPTH && !flush_i));
            if (result_valid_o && exp_q.size() != 0) begin
                chk("id", 64'(result_id_o), 64'(exp_q[0].id));
                chk("data", result_data_o, exp_q[0].data);
                chk("rd", 64'(result_rd_o), 64'(exp_q[0].rd));
                chk("we", 64'(result_we_o), 64'(exp_q[0].we));
                chk("exc", 64'(result_exc_o), 64'(exp_q[0].exc));
                chk("exccode", 64'(result_exccode_o), 64'(exp_q[0].code));
            end
            if (!rst_ni || flush_i) begin
                exp_q.delete();
            end else begin
                acc = res_valid_i && (exp_q.size() < DEPTH);
                pp  = result_ready_i && (exp_q.size() != 0);
                if (pp) void'(exp_q.pop_front());
                if (acc) begin
                    e.id   = res_id_i;
                    e.rd   = res_rd_i;
                    e.we   = res_we_i;
                    e.data = res_we_i ? res_data_i : '0;
`ifdef ARA_XIF_RESULT_EXC_EN
                    e.exc  = res_exc_i;
                    e.code = res_exccode_i;
`else
                    e.exc  = 1'b0;
                    e.code = '0;
`endif
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [IDW-1:0] id,
                         input logic [63:0] d, input logic [4:0] rd,
                         input logic we, input logic exc, input logic [5:0] code,
                         input logic rdy, input logic fl);
        res_valid_i    = v;
        res_id_i       = id;
        res_data_i     = d;
        res_rd_i       = rd;
        res_we_i       = we;
        res_exc_i      = exc;
        res_exccode_i  = code;
        result_ready_i = rdy;
        flush_i        = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0, 0, '0, rdy, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        idle(0, 1);
        rst_ni = 1'b1;
        idle(0, 1);

        // single result
        drive(1, 3, 64'hDEAD, 5, 1, 0, '0, 1, 0);
        idle(1, 2);

        // fill with five pushes, fifth refused, then drain
        for (int i = 0; i < 5; i++) begin
            drive(1, IDW'(i), 64'(i * 17 + 1), 5'(i + 1), 1, 0, '0, 0, 0);
        end
        idle(0, 1);
        idle(1, 5);

        // hold at two entries while pushing and popping across the wrap
        drive(1, 1, 64'h11, 1, 1, 0, '0, 0, 0);
        drive(1, 2, 64'h22, 2, 0, 0, '0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            drive(1, IDW'(i + 3), 64'(i + 100), 5'(i), 1, 0, '0, 1, 0);
        end
        idle(1, 3);

        // flush with three queued and a push in the same cycle
        for (int i = 0; i < 3; i++) drive(1, IDW'(i), 64'(i), 5'(i), 1, 0, '0, 0, 0);
        drive(1, 7, 64'hBAD, 9, 1, 0, '0, 1, 1);
        idle(1, 2);

        // exception fields
        drive(1, 4, 64'h55, 6, 1, 1, 6'd2, 0, 0);
        idle(0, 1);
        idle(1, 1);

        // reset mid-operation
        drive(1, 1, 64'hA, 1, 1, 0, '0, 0, 0);
        drive(1, 2, 64'hB, 2, 1, 0, '0, 0, 0);
        rst_ni = 1'b0;
        idle(0, 1);
        rst_ni = 1'b1;
        idle(0, 2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_ni = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 9) < 6, IDW'($urandom),
                  {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                  1'($urandom), 6'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end
        rst_ni = 1'b1;
        idle(1, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
